fp_accum_seq: RTL and testbench

Sequential accumulation controller placed directly upstream of the combinational single-precision add_sub stage. It accepts a stream of IEEE-754 single-precision operands with a valid/ready handshake and drives the adder's A, B and add_or_sub inputs. It registers the adder's result, overflow and underflow outputs each step. After a programmed number of operands, it presents the final sum and sticky flags with a valid/ready handshake.

---
 rtl/fp_accum_seq.sv | 126 ++++++++++++
 tb/tb_fp_accum_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_accum_seq.sv
// Accumulation controller feeding a combinational single-precision add_sub stage.
// Optional FP_ACC_SAT_EN: clamp the running sum to signed max finite on adder overflow.
module fp_accum_seq #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_sub,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_op,
    input  logic [31:0]      add_result,
    input  logic             add_ovf,
    input  logic             add_udf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_ovf,
    output logic             out_udf,
    output logic             busy,
    output logic [LEN_W-1:0] count
);

    typedef enum logic [2:0] {IDLE, FIRST, FETCH, EXEC, DONE} state_t;

    state_t           state_q;
    logic [31:0]      acc_q, op_q, acc_d;
    logic             op_sub_q, ovf_q, udf_q;
    logic             in_ready_q, out_valid_q, busy_q;
    logic [LEN_W-1:0] cnt_q, len_q;

`ifdef FP_ACC_SAT_EN
    assign acc_d = add_ovf ? (add_result[31] ? 32'hFF7FFFFF : 32'h7F7FFFFF) : add_result;
`else
    assign acc_d = add_result;
`endif

    // The adder only sees a real operation in EXEC; elsewhere its inputs are don't-care.
    assign add_a     = acc_q;
    assign add_b     = op_q;
    assign add_op    = (state_q == EXEC) && op_sub_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;
    assign out_udf   = udf_q;
    assign busy      = busy_q;
    assign count     = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            op_q        <= '0;
            op_sub_q    <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            cnt_q       <= '0;
            len_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    len_q  <= len;
                    acc_q  <= '0;
                    cnt_q  <= '0;
                    ovf_q  <= 1'b0;
                    udf_q  <= 1'b0;
                    busy_q <= 1'b1;
                    if (len == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q    <= FIRST;
                        in_ready_q <= 1'b1;
                    end
                end
                // First operand bypasses the adder: it cannot add to +0.
                FIRST: if (in_valid) begin
                    acc_q <= {in_data[31] ^ in_sub, in_data[30:0]};
                    cnt_q <= LEN_W'(1);
                    if (len_q == LEN_W'(1)) begin
                        state_q     <= DONE;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q <= FETCH;
                    end
                end
                FETCH: if (in_valid) begin
                    op_q       <= in_data;
                    op_sub_q   <= in_sub;
                    cnt_q      <= cnt_q + LEN_W'(1);
                    in_ready_q <= 1'b0;
                    state_q    <= EXEC;
                end
                EXEC: begin
                    acc_q <= acc_d;
                    ovf_q <= ovf_q | add_ovf;
                    udf_q <= udf_q | add_udf;
                    if (cnt_q == len_q) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q    <= FETCH;
                        in_ready_q <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Bench for fp_accum_seq: behavioural FP adder, sequence-level reference model, directed + random runs.
module tb_fp_accum_seq;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst, start, in_valid, in_sub, out_ready;
    logic [LEN_W-1:0] len, count;
    logic [31:0]      in_data, add_a, add_b, add_result, out_data;
    logic             in_ready, add_op, add_ovf, add_udf, out_valid, out_ovf, out_udf, busy;

    logic [31:0] ops [16];
    logic        subs[16];
    logic [31:0] got_data;
    logic        got_ovf;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    fp_accum_seq #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sub(in_sub),
        .add_a(add_a), .add_b(add_b), .add_op(add_op),
        .add_result(add_result), .add_ovf(add_ovf), .add_udf(add_udf),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_udf(out_udf), .busy(busy), .count(count)
    );

    // Truncating single-precision a +/- b for normal operands; returns {ovf, udf, result}.
    function automatic logic [33:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic sa, sb, sr, ts, ovf, udf;
        int ea, eb, e, d, te;
        logic [24:0] ma, mb, m, tm;
        logic [31:0] r;
        sa = a[31]; sb = b[31] ^ sub;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        ma = {2'b01, a[22:0]}; mb = {2'b01, b[22:0]};
        if (ea < eb) begin
            ts = sa; sa = sb; sb = ts;
            te = ea; ea = eb; eb = te;
            tm = ma; ma = mb; mb = tm;
        end
        d = ea - eb;
        mb = (d > 24) ? '0 : (mb >> d);
        e = ea; ovf = 1'b0; udf = 1'b0;
        if (sa == sb) begin
            m = ma + mb; sr = sa;
            if (m[24]) begin m = m >> 1; e++; end
        end else if (ma >= mb) begin
            m = ma - mb; sr = sa;
        end else begin
            m = mb - ma; sr = sb;
        end
        if (m == '0) r = 32'h0;
        else begin
            while (!m[23] && e > 0) begin m = m << 1; e--; end
            if (e >= 255) begin ovf = 1'b1; r = {sr, 8'hFF, 23'h0}; end
            else if (e == 0) begin udf = 1'b1; r = {sr, 31'h0}; end
            else r = {sr, e[7:0], m[22:0]};
        end
        return {ovf, udf, r};
    endfunction

    assign {add_ovf, add_udf, add_result} = fadd(add_a, add_b, add_op);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete run of n operands from ops/subs; lat < 0 skips the latency check.
    task automatic do_run(input int n, input bit gaps, input int stall, input int lat, input bit poke);
        logic [31:0] m_acc;
        logic        m_ovf, m_udf;
        logic [33:0] s;
        int          idx, cyc;
        bit          acc_f;
        m_acc = 32'h0; m_ovf = 1'b0; m_udf = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == 0) m_acc = {ops[0][31] ^ subs[0], ops[0][30:0]};
            else begin
                s = fadd(m_acc, ops[i], subs[i]);
                m_ovf |= s[33]; m_udf |= s[32]; m_acc = s[31:0];
`ifdef FP_ACC_SAT_EN
                if (s[33]) m_acc = s[31] ? 32'hFF7FFFFF : 32'h7F7FFFFF;
`endif
            end
        end
        start = 1'b1; len = LEN_W'(n);
        @(negedge clk);
        start = 1'b0;
        idx = 0; cyc = 0; acc_f = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (acc_f) idx++;
            if (out_valid || cyc > 400) break;
            if (busy && !in_ready) begin
                chk("exec_add_b", add_b, ops[idx-1]);
                chk("exec_add_op", add_op, subs[idx-1]);
            end else if (busy) begin
                chk("idle_add_op", add_op, 1'b0);
            end
            in_valid = (idx < n) && (!gaps || $urandom_range(0, 2) != 0);
            in_data  = ops[idx];
            in_sub   = subs[idx];
            acc_f    = in_valid && in_ready;
        end
        in_valid = 1'b0;
        chk("done_seen", out_valid, 1'b1);
        if (lat >= 0) chk("latency", cyc, lat);
        chk("out_data", out_data, m_acc);
        chk("out_ovf", out_ovf, m_ovf);
        chk("out_udf", out_udf, m_udf);
        chk("count", count, n);
        got_data = out_data; got_ovf = out_ovf;
        for (int k = 0; k < stall; k++) begin
            start = poke && (k == 1);
            len   = LEN_W'(3);
            @(negedge clk);
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, m_acc);
            chk("stall_busy", busy, 1'b1);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", out_valid, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk("post_data", out_data, m_acc);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_sub = 1'b0;
        in_data = '0; out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin ops[i] = '0; subs[i] = 1'b0; end
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_count", count, 0);
        chk("rst_flags", {out_ovf, out_udf}, 2'b00);
        rst = 1'b0;
        @(negedge clk);

        ops[0] = 32'h3F800000; ops[1] = 32'h40000000; ops[2] = 32'h40400000;
        subs[0] = 0; subs[1] = 0; subs[2] = 0;
        do_run(3, 1'b0, 2, 6, 1'b0);
        chk("t1_sum", got_data, 32'h40C00000);

        ops[0] = 32'h40A00000; subs[0] = 0; ops[1] = 32'h40000000; subs[1] = 1;
        do_run(2, 1'b0, 0, 4, 1'b0);
        chk("t2_diff", got_data, 32'h40400000);

        ops[0] = 32'h3FC00000; subs[0] = 1;
        do_run(1, 1'b0, 0, 2, 1'b0);
        chk("t3_neg", got_data, 32'hBFC00000);

        ops[0] = 32'h7F7FFFFF; ops[1] = 32'h7F7FFFFF; subs[0] = 0; subs[1] = 0;
        do_run(2, 1'b0, 0, 4, 1'b0);
        chk("t4_ovf", got_ovf, 1'b1);
`ifdef FP_ACC_SAT_EN
        chk("t4_sat", got_data, 32'h7F7FFFFF);
`else
        chk("t4_raw", got_data, 32'h7F800000);
`endif

        do_run(0, 1'b0, 5, 1, 1'b1);
        chk("t5_zero", got_data, 32'h0);
        @(negedge clk);
        chk("t5_start_ignored", busy, 1'b0);

        // Reset in the middle of a len=4 run, right after the second operand is taken.
        ops[0] = 32'h3F800000; ops[1] = 32'h40000000; subs[0] = 0; subs[1] = 0;
        start = 1'b1; len = LEN_W'(4);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = ops[0]; in_sub = 1'b0;
        @(negedge clk);
        in_data = ops[1];
        @(negedge clk);
        in_valid = 1'b0;
        chk("t6_count_pre", count, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_in_ready", in_ready, 1'b0);
        chk("t6_count", count, 0);
        chk("t6_acc", out_data, 32'h0);
        chk("t6_busy", busy, 1'b0);
        ops[0] = 32'h40400000; subs[0] = 0;
        do_run(1, 1'b0, 0, 2, 1'b0);

        for (int r = 0; r < 25; r++) begin
            int n;
            n = $urandom_range(0, 10);
            for (int i = 0; i < 16; i++) begin
                ops[i]  = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
                subs[i] = 1'($urandom_range(0, 1));
            end
            do_run(n, 1'b1, $urandom_range(0, 3), -1, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
